seg_scan_rx: RTL and testbench
==============================

SEG_SCAN_RX -- requirements
Module: seg_scan_rx

Interface
REQ-001 Parameter STABLE, default 4: number of consecutive identical samples required before a display pattern is accepted; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 65535: number of idle cycles with no accepted digit before all digit-valid flags clear; legal range 1..2^20-1.
REQ-003 clk  input  1  single system clock; all logic samples on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 an  input  4  display anode lines, active-low; an[i]=0 selects digit i.
REQ-006 sgm  input  8  segment lines, active-low; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
REQ-007 digits  output  16  recovered hex values; digit i occupies bits [4i+3:4i].
REQ-008 dp  output  4  recovered decimal-point state per digit; 1 = dp lit.
REQ-009 dvalid  output  4  per-digit flag; 1 = the digit holds a pattern captured since reset or since the last timeout.
REQ-010 upd  output  1  one-cycle pulse on every accepted capture.
REQ-011 frame  output  1  one-cycle pulse when all four digits have been captured since the previous frame pulse.
REQ-012 err_pat  output  1  one-cycle pulse when a stable pattern has no legal hex encoding.
REQ-013 err_an  output  1  one-cycle pulse when a stable anode vector has more than one line low.

Function
REQ-014 an and sgm SHALL pass through a 2-flop synchronizer; all further logic uses the synchronized copies (an_s, sgm_s).
REQ-015 The FSM SHALL have exactly three states: WAIT, SETTLE, HOLD.
REQ-016 WAIT: when {an_s, sgm_s} differs from the previous cycle's value, load the counter with 1 and go to SETTLE.
REQ-017 SETTLE: if the input is unchanged, increment the counter; if the input changes, reload the counter with 1 and stay in SETTLE.
REQ-018 SETTLE: when the counter reaches STABLE with the input unchanged, evaluate the pattern and go to HOLD.
REQ-019 HOLD: any change in {an_s, sgm_s} returns the FSM to SETTLE with the counter loaded to 1.
REQ-020 Evaluation with an_s = 4'b1111 (blank): no capture, no error.
REQ-021 Evaluation with more than one an_s bit low: pulse err_an; no capture.
REQ-022 Evaluation with exactly one an_s bit low and sgm_s[7:1] matching a legal encoding: write the hex value to the digit slot, write dp = ~sgm_s[0], set dvalid[i], and pulse upd.
REQ-023 Evaluation with exactly one an_s bit low and sgm_s[7:1] not matching any legal encoding: pulse err_pat; digit slot and dvalid unchanged.
REQ-024 Legal segment encodings (sgm[7:1], active-low), one per hex value:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, B=1100000
- C=0110001, D=1000010, E=0110000, F=0111000
REQ-025 Latency: upd SHALL assert STABLE+3 cycles after a change on the raw pins; digits, dp and dvalid update in the same cycle as upd.
REQ-026 Frame tracking: a 4-bit seen mask sets bit i on each capture of digit i.
- When the mask becomes 4'b1111, frame pulses in that same cycle and the mask clears.
- A repeated capture of an already-seen digit does not pulse frame.
REQ-027 Idle counter: clears on every upd and increments otherwise, saturating at its maximum.
- When it reaches TIMEOUT, dvalid and the seen mask clear; digits and dp keep their values.
REQ-028 upd, frame, err_pat and err_an SHALL never be high for more than one consecutive cycle per evaluation.

Reset
REQ-029 With rst_n=0, all outputs are immediately 0 and the FSM is in WAIT.
- Synchronizers, counters and the seen mask are also cleared.
REQ-030 Reset asserted mid-SETTLE or mid-HOLD discards any pending evaluation; no pulse is emitted on release.
REQ-031 After release, the first evaluation requires a full STABLE-sample window.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the 16-entry segment table and the anode-blank constant.
REQ-033 Reverse lookup SHALL be one combinational sub-module, sgm2hex (in: 7-bit pattern; out: 4-bit value and legal flag), instantiated once.

Verification
REQ-034 Reset, then an=1110, sgm=00100101 held for 10 cycles, STABLE=4 -> upd on cycle 7 after the change; digits[3:0]=2, dp[0]=0, dvalid=0001.
REQ-035 Scan digits 0..3 with patterns for 1, A, C, F plus dp on digit 3 -> frame pulses once; digits=16'hFCA1, dp=1000, dvalid=1111.
REQ-036 sgm toggles every 2 cycles with STABLE=4 -> no upd; then holding the input -> exactly one upd.
REQ-037 an=1100 held stable -> one err_an pulse; an=1110 with sgm=11111110 -> one err_pat pulse; digits unchanged in both cases.
REQ-038 TIMEOUT=20, capture one digit, then hold blank -> dvalid clears exactly 20 cycles after upd; digits retained.
REQ-039 rst_n pulled low during SETTLE -> outputs 0 at once; no upd after release until a new STABLE window completes.

Source files
------------

// File: rtl/seg_scan_rx_pkg.sv
// Shared types and constants for the seven-segment scan receiver.
package seg_scan_rx_pkg;

  typedef enum logic [1:0] {
    StWait,
    StSettle,
    StHold
  } state_e;

  // Anode vector with no digit selected.
  localparam logic [3:0] AnBlank = 4'b1111;

  // Active-low segment patterns sgm[7:1] (a..g); element i encodes hex value i.
  localparam logic [15:0][6:0] SegTable = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // True when exactly one active-low anode line is asserted.
  function automatic logic one_low(input logic [3:0] an_vec);
    logic [3:0] z;
    z = ~an_vec;
    return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_scan_rx_sgm2hex.sv
// Reverse lookup of an active-low segment pattern to its hex value.
module sgm2hex
  import seg_scan_rx_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       legal
);

  // Search the table; patterns are unique so at most one entry matches.
  always_comb begin
    val   = 4'd0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (SegTable[i] == pat) begin
        val   = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Recovers hex digits from a multiplexed, active-low seven-segment display bus.
module seg_scan_rx
  import seg_scan_rx_pkg::*;
#(
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  sgm,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  dvalid,
  output logic        upd,
  output logic        frame,
  output logic        err_pat,
  output logic        err_an
);

  localparam logic [7:0]  StableCnt = 8'(STABLE);
  localparam logic [19:0] TimeoutM1 = 20'(TIMEOUT - 1);
  localparam logic [19:0] IdleMax   = 20'hFFFFF;

  logic [3:0]  an_m, an_s;
  logic [7:0]  sgm_m, sgm_s;
  logic [11:0] prev_q;
  logic        changed;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        eval;
  logic        eval_q;
  logic [11:0] pat_q;

  logic [3:0]  hex_val;
  logic        hex_legal;
  logic [1:0]  idx;
  logic        capture, bad_an, bad_pat;

  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_q, dp_d, dvalid_q, dvalid_d, seen_q, seen_d, seen_or;
  logic [19:0] idle_q, idle_d;
  logic        upd_q, frame_q, frame_d, err_pat_q, err_an_q;

  // Two-flop synchronizer plus last-cycle copy for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m   <= 4'd0;
      an_s   <= 4'd0;
      sgm_m  <= 8'd0;
      sgm_s  <= 8'd0;
      prev_q <= 12'd0;
    end else begin
      an_m   <= an;
      an_s   <= an_m;
      sgm_m  <= sgm;
      sgm_s  <= sgm_m;
      prev_q <= {an_s, sgm_s};
    end
  end

  assign changed = ({an_s, sgm_s} != prev_q);

  // Stability FSM state, sample counter and the latched pattern awaiting decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWait;
      cnt_q   <= 8'd0;
      eval_q  <= 1'b0;
      pat_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eval_q  <= eval;
      if (eval) pat_q <= {an_s, sgm_s};
    end
  end

  // Counter holds the number of identical samples seen, including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    unique case (state_q)
      StWait, StHold: begin
        if (changed) begin
          cnt_d = 8'd1;
          if (cnt_d == StableCnt) begin
            eval    = 1'b1;
            state_d = StHold;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        cnt_d = changed ? 8'd1 : cnt_q + 8'd1;
        if (cnt_d == StableCnt) begin
          eval    = 1'b1;
          state_d = StHold;
        end
      end
      default: state_d = StWait;
    endcase
  end

  sgm2hex u_sgm2hex (
    .pat   (pat_q[7:1]),
    .val   (hex_val),
    .legal (hex_legal)
  );

  // Selected digit index from the active-low anode vector.
  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!pat_q[8 + i]) idx = 2'(i);
    end
  end

  assign capture = eval_q && one_low(pat_q[11:8]) && hex_legal;
  assign bad_pat = eval_q && one_low(pat_q[11:8]) && !hex_legal;
  assign bad_an  = eval_q && (pat_q[11:8] != AnBlank) && !one_low(pat_q[11:8]);

  // Digit store, frame tracking and idle timeout next state.
  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    dvalid_d = dvalid_q;
    seen_d   = seen_q;
    seen_or  = seen_q;
    frame_d  = 1'b0;
    idle_d   = idle_q;
    if (capture) begin
      digits_d[{idx, 2'b00} +: 4] = hex_val;
      dp_d[idx]     = ~pat_q[0];
      dvalid_d[idx] = 1'b1;
      seen_or       = seen_q | (4'b0001 << idx);
      if (seen_or == 4'b1111) begin
        frame_d = 1'b1;
        seen_d  = 4'd0;
      end else begin
        seen_d = seen_or;
      end
      idle_d = 20'd0;
    end else begin
      if (idle_q != IdleMax) idle_d = idle_q + 20'd1;
      // Clear on the cycle the idle count reaches TIMEOUT.
      if (idle_q == TimeoutM1) begin
        dvalid_d = 4'd0;
        seen_d   = 4'd0;
      end
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= 16'd0;
      dp_q      <= 4'd0;
      dvalid_q  <= 4'd0;
      seen_q    <= 4'd0;
      idle_q    <= 20'd0;
      upd_q     <= 1'b0;
      frame_q   <= 1'b0;
      err_pat_q <= 1'b0;
      err_an_q  <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      dvalid_q  <= dvalid_d;
      seen_q    <= seen_d;
      idle_q    <= idle_d;
      upd_q     <= capture;
      frame_q   <= frame_d;
      err_pat_q <= bad_pat;
      err_an_q  <= bad_an;
    end
  end

  assign digits  = digits_q;
  assign dp      = dp_q;
  assign dvalid  = dvalid_q;
  assign upd     = upd_q;
  assign frame   = frame_q;
  assign err_pat = err_pat_q;
  assign err_an  = err_an_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Randomized scoreboard bench for seg_scan_rx with a run-length reference model.
module tb_seg_scan_rx;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  sgm = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp, dvalid;
  logic        upd, frame, err_pat, err_an;

  seg_scan_rx #(
    .STABLE  (STABLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .an      (an),
    .sgm     (sgm),
    .digits  (digits),
    .dp      (dp),
    .dvalid  (dvalid),
    .upd     (upd),
    .frame   (frame),
    .err_pat (err_pat),
    .err_an  (err_an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [7:0] sgm;
  } ev_t;

  ev_t  evq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_print = 0;
  int   cyc = 0;
  int   last_cap = 0;
  int   n_frame_dut = 0;
  logic [6:0] seg_tab [16];

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
  end

  function automatic int find_code(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
    end
  endtask

  // Reference sampler: a pattern is evaluated once per run of STABLE identical samples.
  initial begin
    logic [11:0] last_raw, raw;
    int run;
    logic armed;
    last_raw = 12'd0; run = 0; armed = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        last_cap = cyc;
        last_raw = 12'd0;
        run = 0;
        armed = 1'b0;
      end else begin
        raw = {an, sgm};
        if (raw != last_raw) begin
          run = 1;
          armed = 1'b1;
        end else if (run < 1000) begin
          run++;
        end
        last_raw = raw;
        if (armed && run == STABLE) evq.push_back('{due: cyc + 3, an: an, sgm: sgm});
      end
    end
  end

  // Monitor: pops due evaluations, advances the expected display state, compares outputs.
  initial begin
    logic [15:0] e_dig;
    logic [3:0]  e_dp, e_dv, seen;
    logic        e_upd, e_frame, e_ep, e_ea, cap;
    ev_t         e;
    int          nz, ix, code;
    e_dig = '0; e_dp = '0; e_dv = '0; seen = '0;
    forever begin
      @(negedge clk);
      if (frame) n_frame_dut++;
      e_upd = 1'b0; e_frame = 1'b0; e_ep = 1'b0; e_ea = 1'b0; cap = 1'b0;
      if (!rst_n) begin
        evq.delete();
        e_dig = '0; e_dp = '0; e_dv = '0; seen = '0;
      end else begin
        while (evq.size() > 0 && evq[0].due < cyc) begin
          e = evq.pop_front();
          check("missed_event", 32'(cyc), 32'(e.due));
        end
        if (evq.size() > 0 && evq[0].due == cyc) begin
          e = evq.pop_front();
          nz = 0; ix = 0;
          for (int i = 0; i < 4; i++) if (!e.an[i]) begin nz++; ix = i; end
          if (nz > 1) e_ea = 1'b1;
          else if (nz == 1) begin
            code = find_code(e.sgm[7:1]);
            if (code < 0) e_ep = 1'b1;
            else begin
              cap = 1'b1;
              e_upd = 1'b1;
              e_dig[ix*4 +: 4] = 4'(code);
              e_dp[ix] = ~e.sgm[0];
              e_dv[ix] = 1'b1;
              seen[ix] = 1'b1;
              if (seen == 4'hF) begin e_frame = 1'b1; seen = 4'h0; end
              last_cap = cyc;
            end
          end
        end
        if (!cap && (cyc - last_cap == TIMEOUT)) begin
          e_dv = 4'h0;
          seen = 4'h0;
        end
      end
      check("outputs", 32'({upd, frame, err_pat, err_an, digits, dp, dvalid}),
            32'({e_upd, e_frame, e_ep, e_ea, e_dig, e_dp, e_dv}));
    end
  end

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    sgm = s;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({upd, frame, err_pat, err_an, digits, dp, dvalid}), 32'd0);
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r, nfb;
    logic [3:0] a;
    logic [7:0] s;
    logic [6:0] tmp;
    #1;
    do_reset(3);
    hold(4'hF, 8'hFF, 8);

    // Single capture of '2' on digit 0.
    hold(4'b1110, 8'b00100101, 10);
    check("first_digit", 32'(digits[3:0]), 32'd2);
    check("first_dvalid", 32'(dvalid), 32'b0001);
    check("first_dp", 32'(dp[0]), 32'd0);

    // Scan 1, A, C, F with dp lit on digit 3.
    nfb = n_frame_dut;
    tmp = seg_tab[1];  hold(4'b1110, {tmp, 1'b1}, 8);
    tmp = seg_tab[10]; hold(4'b1101, {tmp, 1'b1}, 8);
    tmp = seg_tab[12]; hold(4'b1011, {tmp, 1'b1}, 8);
    tmp = seg_tab[15]; hold(4'b0111, {tmp, 1'b0}, 8);
    check("scan_digits", 32'(digits), 32'hFCA1);
    check("scan_dp", 32'(dp), 32'b1000);
    check("scan_dvalid", 32'(dvalid), 32'hF);
    check("scan_frames", 32'(n_frame_dut - nfb), 32'd1);

    // Unsettled toggling, then a steady hold.
    for (int i = 0; i < 10; i++) begin
      tmp = seg_tab[i[0] ? 3 : 8];
      hold(4'b1101, {tmp, 1'b1}, 2);
    end
    hold(4'b1101, 8'b00001101, 10);

    // Multi-anode and illegal pattern errors.
    hold(4'b1100, 8'b00000011, 10);
    hold(4'b1110, 8'b11111110, 10);

    // Capture then idle into timeout.
    hold(4'b1011, 8'b10011111, 8);
    hold(4'hF, 8'hFF, 30);

    // Reset during a settle window.
    hold(4'b1101, 8'b01001001, 2);
    do_reset(3);
    hold(4'b1101, 8'b01001001, 10);

    // Randomized traffic.
    repeat (180) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        if (r < 14) a = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 16) a = 4'hF;
        else a = 4'($urandom);
        if (r < 12) begin
          tmp = seg_tab[$urandom_range(0, 15)];
          s = {tmp, 1'($urandom_range(0, 1))};
        end else begin
          s = 8'($urandom);
        end
        hold(a, s, (r == 19) ? 25 : $urandom_range(1, 10));
      end
    end

    hold(4'hF, 8'hFF, 12);
    check("queue_drained", 32'(evq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
